fc_neuron_mac: RTL

- Sequential multiply-accumulate neuron for the VAE level-1 datapath.
- Consumes a stream of K (activation, weight) pairs in signed Q(N-Q).Q fixed point, then adds a bias.
- Rounds and saturates the sum to N bits and presents the pre-activation y, which drives the x input of softplus8 directly.
- Valid/ready handshakes on both sides; one result per K accepted pairs.

---
 rtl/fc_neuron_mac.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fc_neuron_mac.sv
// Purpose : sequential multiply-accumulate neuron. It takes K (x, w) pairs plus a bias and produces one rounded, saturated pre-activation y.
// Latency : y is valid 1 cycle after the last accepted pair.
// Backpressure: while a result waits for out_ready, in_ready stays low. A new vector starts on the cycle after the handshake.
//
// Ports:
//   clk, rst_n           - clock and synchronous active-low reset
//   in_valid/in_ready    - (x_in, w_in) pair handshake; bias is sampled on the first beat
//   x_in, w_in, bias     - signed Q(N-Q).Q operands
//   out_valid/out_ready  - result handshake
//   y, sat               - saturated Q(N-Q).Q result and clip flag (qualified by out_valid)
module fc_neuron_mac #(
    parameter int N     = 16,
    parameter int Q     = 12,
    parameter int K     = 8,
    parameter int ACC_W = 40
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x_in,
    input  logic [N-1:0] w_in,
    input  logic [N-1:0] bias,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic         sat
);

    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

    // Rounding constant and saturation limits, expressed at the width of the final sum.
    localparam logic signed [ACC_W:0] RND   = {{(ACC_W+1-Q){1'b0}}, 1'b1, {(Q-1){1'b0}}};
    localparam logic signed [ACC_W:0] R_MAX = {{(ACC_W+2-N){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [ACC_W:0] R_MIN = {{(ACC_W+2-N){1'b1}}, {(N-1){1'b0}}};

    typedef enum logic {ST_ACC, ST_OUT} state_t;

    state_t                    state;
    logic [CNT_W-1:0]          cnt;
    logic signed [ACC_W-1:0]   acc;
    logic signed [N-1:0]       bias_q;

    logic                      accept;
    logic                      first_beat;
    logic                      last_beat;
    logic signed [2*N-1:0]     prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [N-1:0]       bias_sel;
    logic signed [ACC_W:0]     bias_ext;
    logic signed [ACC_W:0]     s_full;
    logic signed [ACC_W:0]     s_rnd;
    logic signed [ACC_W:0]     r;
    logic [N-1:0]              y_nxt;
    logic                      sat_nxt;

    assign in_ready   = (state == ST_ACC);
    assign accept     = in_valid & in_ready;
    assign first_beat = (cnt == '0);
    assign last_beat  = (cnt == CNT_W'(K-1));

    always_comb begin
        prod     = $signed(x_in) * $signed(w_in);
        prod_ext = {{(ACC_W-2*N){prod[2*N-1]}}, prod};
        // On the first beat the stale accumulator is ignored, so no separate clear cycle is needed.
        acc_sum  = (first_beat ? '0 : acc) + prod_ext;
        // With K=1 the first beat is also the last one, so the bias comes straight from the port.
        bias_sel = first_beat ? $signed(bias) : bias_q;
        bias_ext = {{(ACC_W+1-N){bias_sel[N-1]}}, bias_sel};
        s_full   = {acc_sum[ACC_W-1], acc_sum} + (bias_ext <<< Q);
        s_rnd    = s_full + RND;
        r        = s_rnd >>> Q;

        y_nxt    = r[N-1:0];
        sat_nxt  = 1'b0;
        if (r > R_MAX) begin
            y_nxt   = {1'b0, {(N-1){1'b1}}};
            sat_nxt = 1'b1;
        end else if (r < R_MIN) begin
            y_nxt   = {1'b1, {(N-1){1'b0}}};
            sat_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_ACC;
            cnt       <= '0;
            acc       <= '0;
            bias_q    <= '0;
            out_valid <= 1'b0;
            y         <= '0;
            sat       <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (accept) begin
                        acc <= acc_sum;
                        if (first_beat) begin
                            bias_q <= $signed(bias);
                        end
                        if (last_beat) begin
                            cnt       <= '0;
                            state     <= ST_OUT;
                            out_valid <= 1'b1;
                            y         <= y_nxt;
                            sat       <= sat_nxt;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_ACC;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end

endmodule
